seq_storage_trio: RTL and testbench

- Three reference storage elements driven by one shared data input, clock and reset: a level-sensitive D latch, a D flip-flop with asynchronous clear, and a D flip-flop with synchronous clear.
- Used as a teaching/characterisation block. It shows how transparency and reset timing differ between latches and flip-flops on the same stimulus.
- Outputs are exposed side by side so a bench can compare them cycle by cycle.

---
 rtl/seq_storage_trio.sv | 78 +++++++
 tb/tb_seq_storage_trio.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seq_storage_trio.sv
// -----------------------------------------------------------------------------
// seq_storage_trio
//
// Three reference storage elements fed by one data input, one clock and one
// active-low reset, exposed side by side so their transparency and reset
// timing can be compared on identical stimulus:
//   - a level-sensitive D latch (transparent while clk is high),
//   - a rising-edge D flip-flop with asynchronous clear,
//   - a rising-edge D flip-flop with synchronous clear.
//
// Ports:
//   clk        in   1      clock; latch enable (high) and flop sampling edge
//   rst_n      in   1      active-low reset, driven synchronous to clk
//   d          in   WIDTH  shared data input
//   q_latch    out  WIDTH  D-latch output
//   q_async    out  WIDTH  flop output, asynchronously cleared
//   q_sync     out  WIDTH  flop output, synchronously cleared
//   q_mismatch out  1      high while the three outputs are not all equal
// -----------------------------------------------------------------------------
module seq_storage_trio #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_latch,
    output logic [WIDTH-1:0] q_async,
    output logic [WIDTH-1:0] q_sync,
    output logic             q_mismatch
);

    logic [WIDTH-1:0] q_latch_r;
    logic [WIDTH-1:0] q_async_r;
    logic [WIDTH-1:0] q_sync_r;
    logic [WIDTH-1:0] sync_next_s;

    // Level-sensitive latch: reset wins at any clk level, transparent while
    // clk is high, holds the value seen at the falling edge while clk is low.
    always_latch begin
        if (!rst_n) begin
            q_latch_r <= {WIDTH{1'b0}};
        end else if (clk) begin
            q_latch_r <= d;
        end
    end

    // Edge flop whose clear acts on the falling edge of rst_n without waiting
    // for the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_async_r <= {WIDTH{1'b0}};
        end else begin
            q_async_r <= d;
        end
    end

    // Next value of the synchronously cleared flop. Reset is folded into the
    // data path here so a low pulse between rising edges cannot reach it.
    always_comb begin
        sync_next_s = {WIDTH{1'b0}};
        if (rst_n) begin
            sync_next_s = d;
        end else begin
            sync_next_s = {WIDTH{1'b0}};
        end
    end

    // Edge flop with synchronous clear, sampling only on the rising edge.
    always_ff @(posedge clk) begin
        q_sync_r <= sync_next_s;
    end

    assign q_latch    = q_latch_r;
    assign q_async    = q_async_r;
    assign q_sync     = q_sync_r;
    assign q_mismatch = ~((q_latch_r == q_async_r) && (q_async_r == q_sync_r));

endmodule

// File: tb/tb_seq_storage_trio.sv
// -----------------------------------------------------------------------------
// tb_seq_storage_trio
//
// Drives the three storage elements through directed reset/capture/latch
// scenarios followed by randomized cycles. Each clock period is split into
// four observation points (low phase after drive, just after the rising
// edge, high phase after a mid-phase data change, just after the falling
// edge); the expected outputs are derived per phase from the behavioural
// rules of each element.
// -----------------------------------------------------------------------------
module tb_seq_storage_trio;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] d;
    logic [W-1:0] q_latch;
    logic [W-1:0] q_async;
    logic [W-1:0] q_sync;
    logic         q_mismatch;

    logic [W-1:0] exp_latch;
    logic [W-1:0] exp_async;
    logic [W-1:0] exp_sync;

    int n_vectors     = 0;
    int n_miscompares = 0;

    seq_storage_trio #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d          (d),
        .q_latch    (q_latch),
        .q_async    (q_async),
        .q_sync     (q_sync),
        .q_mismatch (q_mismatch)
    );

    // Free-running clock, period 10, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string phase);
        logic exp_mm;
        exp_mm = !((exp_latch == exp_async) && (exp_async == exp_sync));
        check_value({"q_latch_", phase},    32'(q_latch),    32'(exp_latch));
        check_value({"q_async_", phase},    32'(q_async),    32'(exp_async));
        check_value({"q_sync_", phase},     32'(q_sync),     32'(exp_sync));
        check_value({"q_mismatch_", phase}, 32'(q_mismatch), 32'(exp_mm));
    endtask

    // One clock period, entered 1 time unit after a falling edge.
    // rst_v and d_low are applied mid low phase; d_high mid high phase.
    task automatic run_cycle(input logic rst_v, input logic [W-1:0] d_low,
                             input logic [W-1:0] d_high);
        #1;
        rst_n = rst_v;
        d     = d_low;
        // Low phase: reset clears latch and async flop at once; the latch
        // otherwise keeps its falling-edge value; the sync flop waits.
        if (!rst_v) begin
            exp_latch = '0;
            exp_async = '0;
        end
        #1;
        check_all("low");

        @(posedge clk);
        #1;
        // Rising edge: both flops load d (or 0 under reset); latch opens.
        exp_async = rst_v ? d_low : '0;
        exp_sync  = rst_v ? d_low : '0;
        exp_latch = rst_v ? d_low : '0;
        check_all("rise");

        #1;
        d = d_high;
        // Mid high phase: only the transparent latch sees the new d.
        if (rst_v) begin
            exp_latch = d_high;
        end
        #1;
        check_all("high");

        @(negedge clk);
        #1;
        // Falling edge: latch closes on the last high-phase value.
        check_all("fall");
    endtask

    initial begin
        logic         rst_v;
        logic [W-1:0] dl;
        logic [W-1:0] dh;

        rst_n     = 1'b0;
        d         = '0;
        exp_latch = '0;
        exp_async = '0;
        exp_sync  = '0;

        @(negedge clk);
        #1;

        // Power-on reset with one rising edge.
        run_cycle(1'b0, '0, '0);
        // Release and capture 0.
        run_cycle(1'b1, '0, '0);
        // Capture all-ones, then drop d mid high phase (latch vs flop).
        run_cycle(1'b1, '1, '0);
        // Next edge with d=0 brings everything back to 0.
        run_cycle(1'b1, '0, '0);
        // Latch hold: d rises during low phase, then edge loads all-ones.
        run_cycle(1'b1, '1, '1);
        // Reset asserted mid low phase from all-ones.
        run_cycle(1'b0, '1, '1);
        // Release with d all-ones.
        run_cycle(1'b1, '1, '1);
        // Mixed per-bit pattern.
        run_cycle(1'b1, 4'b1010, 4'b0101);

        for (int i = 0; i < 300; i++) begin
            rst_v = ($urandom_range(0, 7) != 0);
            dl    = W'($urandom);
            dh    = W'($urandom);
            run_cycle(rst_v, dl, dh);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
